// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared state encoding and next-PC source indices
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_EXC_JUMP = 1'b1
  } pc_state_t;

  localparam int SRC_ALU    = 0;
  localparam int SRC_ALUOUT = 1;
  localparam int SRC_CONCAT = 2;
  localparam int SRC_MDR    = 3;
  localparam int SRC_EPC    = 4;

  localparam int EXC_CODE_W = 2;

endpackage

`default_nettype wire

// File: rtl/pc_src_mux.sv
// ============================================================================
// pc_src_mux : NUM_SRC-way flattened-bus mux with out-of-range flag
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_src_mux #(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 5,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_SRC*DATA_W-1:0] bus,
  output logic [DATA_W-1:0]         out,
  output logic                      out_of_range
);

  always_comb begin
    out = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel == SEL_W'(k)) begin
        out = bus[k*DATA_W +: DATA_W];
      end
    end
  end

  // Unreachable when NUM_SRC is a power of two; the compare then folds away.
  assign out_of_range = ({{(32 - SEL_W){1'b0}}, sel} >= 32'(NUM_SRC));

endmodule

`default_nettype wire

// File: rtl/pc_next_unit.sv
// ============================================================================
// pc_next_unit : next-PC selection, PC/EPC registers and exception redirect
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_next_unit
  import cpu_pkg::*;
#(
  parameter int              DATA_W    = 32,
  parameter int              NUM_SRC   = 5,
  parameter logic [DATA_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [DATA_W-1:0] EXC_BASE = 32'h0000_0400,
  parameter bit              ALIGN_CHK = 1'b1,
  localparam int             SEL_W     = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SEL_W-1:0]          src_sel,
  input  logic [NUM_SRC*DATA_W-1:0] src_bus,
  input  logic                      pc_write,
  input  logic                      pc_write_cond,
  input  logic                      cond_true,
  input  logic                      exc_req,
  input  logic [EXC_CODE_W-1:0]     exc_code,
  output logic [DATA_W-1:0]         pc_out,
  output logic [DATA_W-1:0]         epc_out,
  output logic                      busy,
  output logic                      sel_err,
  output logic                      align_err
);

  pc_state_t             state;
  logic [EXC_CODE_W-1:0] code;
  logic [DATA_W-1:0]     target;
  logic                  sel_oor;
  logic                  do_wr;
  logic                  misaligned;
  logic [DATA_W-1:0]     exc_vector;

  pc_src_mux #(
    .DATA_W  (DATA_W),
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_src_mux (
    .sel          (src_sel),
    .bus          (src_bus),
    .out          (target),
    .out_of_range (sel_oor)
  );

  assign do_wr      = pc_write | (pc_write_cond & cond_true);
  assign misaligned = ALIGN_CHK && (target[1:0] != 2'b00);
  // Vector offset is the cause scaled to a word index; the add wraps silently.
  assign exc_vector = EXC_BASE + DATA_W'({code, 2'b00});

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      pc_out    <= RESET_PC;
      epc_out   <= '0;
      code      <= '0;
      busy      <= 1'b0;
      sel_err   <= 1'b0;
      align_err <= 1'b0;
    end else begin
      align_err <= 1'b0;
      case (state)
        ST_RUN: begin
          if (exc_req) begin
            epc_out <= pc_out;
            code    <= exc_code;
            state   <= ST_EXC_JUMP;
            busy    <= 1'b1;
          end else if (do_wr) begin
            if (sel_oor) begin
              sel_err <= 1'b1;
            end else if (misaligned) begin
              align_err <= 1'b1;
            end else begin
              pc_out <= target;
            end
          end
        end
        ST_EXC_JUMP: begin
          pc_out <= exc_vector;
          state  <= ST_RUN;
          busy   <= 1'b0;
        end
        default: begin
          state <= ST_RUN;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_next_unit.sv
// ============================================================================
// tb_pc_next_unit : directed self-checking bench for pc_next_unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pc_next_unit;

  localparam int DATA_W  = 32;
  localparam int NUM_SRC = 5;
  localparam int SEL_W   = 3;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [SEL_W-1:0]          src_sel;
  logic [NUM_SRC*DATA_W-1:0] src_bus;
  logic                      pc_write;
  logic                      pc_write_cond;
  logic                      cond_true;
  logic                      exc_req;
  logic [1:0]                exc_code;
  logic [DATA_W-1:0]         pc_out;
  logic [DATA_W-1:0]         epc_out;
  logic                      busy;
  logic                      sel_err;
  logic                      align_err;

  int checks = 0;
  int fails  = 0;

  pc_next_unit dut (
    .clk           (clk),
    .reset         (reset),
    .src_sel       (src_sel),
    .src_bus       (src_bus),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .cond_true     (cond_true),
    .exc_req       (exc_req),
    .exc_code      (exc_code),
    .pc_out        (pc_out),
    .epc_out       (epc_out),
    .busy          (busy),
    .sel_err       (sel_err),
    .align_err     (align_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cand(input int k, input logic [DATA_W-1:0] v);
    src_bus[k*DATA_W +: DATA_W] = v;
  endtask

  task automatic idle_inputs();
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    cond_true     = 1'b0;
    exc_req       = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    src_sel  = '0;
    exc_code = '0;
    src_bus  = '0;
    step();
    step();
    reset = 1'b0;
    step();
    checks++; if (pc_out !== 32'h0) begin fails++; $display("FAIL reset_pc got=%h exp=%h", pc_out, 32'h0); end
    checks++; if (epc_out !== 32'h0) begin fails++; $display("FAIL reset_epc got=%h exp=%h", epc_out, 32'h0); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (sel_err !== 1'b0) begin fails++; $display("FAIL reset_sel_err got=%b exp=0", sel_err); end
    checks++; if (align_err !== 1'b0) begin fails++; $display("FAIL reset_align_err got=%b exp=0", align_err); end
  endtask

  task automatic test_uncond_write();
    set_cand(0, 32'h0000_0010);
    set_cand(1, 32'h0000_2000);
    set_cand(2, 32'h0040_0010);
    set_cand(3, 32'h0000_3000);
    set_cand(4, 32'h0000_4000);
    src_sel  = 3'd2;
    pc_write = 1'b1;
    step();
    pc_write = 1'b0;
    checks++; if (pc_out !== 32'h0040_0010) begin fails++; $display("FAIL uncond_write got=%h exp=%h", pc_out, 32'h0040_0010); end
  endtask

  task automatic test_cond_write();
    src_sel       = 3'd1;
    pc_write_cond = 1'b1;
    cond_true     = 1'b0;
    step();
    checks++; if (pc_out !== 32'h0040_0010) begin fails++; $display("FAIL cond_false got=%h exp=%h", pc_out, 32'h0040_0010); end
    cond_true = 1'b1;
    step();
    checks++; if (pc_out !== 32'h0000_2000) begin fails++; $display("FAIL cond_true got=%h exp=%h", pc_out, 32'h0000_2000); end
    // Both write strobes high with a false condition still writes.
    cond_true = 1'b0;
    pc_write  = 1'b1;
    src_sel   = 3'd3;
    step();
    checks++; if (pc_out !== 32'h0000_3000) begin fails++; $display("FAIL both_strobes got=%h exp=%h", pc_out, 32'h0000_3000); end
    idle_inputs();
  endtask

  task automatic test_exception();
    set_cand(1, 32'h0000_0100);
    src_sel  = 3'd1;
    pc_write = 1'b1;
    step();
    checks++; if (pc_out !== 32'h0000_0100) begin fails++; $display("FAIL exc_setup_pc got=%h exp=%h", pc_out, 32'h100); end
    exc_req  = 1'b1;
    exc_code = 2'd2;
    src_sel  = 3'd4;
    step();
    exc_req  = 1'b0;
    exc_code = 2'd0;
    src_sel  = 3'd3;
    checks++; if (epc_out !== 32'h0000_0100) begin fails++; $display("FAIL exc_epc got=%h exp=%h", epc_out, 32'h100); end
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL exc_busy_set got=%b exp=1", busy); end
    checks++; if (pc_out !== 32'h0000_0100) begin fails++; $display("FAIL exc_pc_held got=%h exp=%h", pc_out, 32'h100); end
    step();
    pc_write = 1'b0;
    checks++; if (pc_out !== 32'h0000_0408) begin fails++; $display("FAIL exc_vector got=%h exp=%h", pc_out, 32'h408); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL exc_busy_clr got=%b exp=0", busy); end
  endtask

  task automatic test_exc_code3();
    exc_req  = 1'b1;
    exc_code = 2'd3;
    step();
    exc_req = 1'b0;
    step();
    checks++; if (epc_out !== 32'h0000_0408) begin fails++; $display("FAIL code3_epc got=%h exp=%h", epc_out, 32'h408); end
    checks++; if (pc_out !== 32'h0000_040C) begin fails++; $display("FAIL code3_vector got=%h exp=%h", pc_out, 32'h40C); end
  endtask

  task automatic test_sel_err();
    src_sel  = 3'd6;
    pc_write = 1'b1;
    step();
    pc_write = 1'b0;
    src_sel  = 3'd0;
    checks++; if (pc_out !== 32'h0000_040C) begin fails++; $display("FAIL sel_err_pc_held got=%h exp=%h", pc_out, 32'h40C); end
    checks++; if (sel_err !== 1'b1) begin fails++; $display("FAIL sel_err_set got=%b exp=1", sel_err); end
    step();
    step();
    checks++; if (sel_err !== 1'b1) begin fails++; $display("FAIL sel_err_sticky got=%b exp=1", sel_err); end
  endtask

  task automatic test_align();
    set_cand(0, 32'h0000_0102);
    src_sel  = 3'd0;
    pc_write = 1'b1;
    step();
    pc_write = 1'b0;
    checks++; if (align_err !== 1'b1) begin fails++; $display("FAIL align_pulse got=%b exp=1", align_err); end
    checks++; if (pc_out !== 32'h0000_040C) begin fails++; $display("FAIL align_pc_held got=%h exp=%h", pc_out, 32'h40C); end
    step();
    checks++; if (align_err !== 1'b0) begin fails++; $display("FAIL align_pulse_end got=%b exp=0", align_err); end
  endtask

  task automatic test_reset_mid_exception();
    exc_req  = 1'b1;
    exc_code = 2'd1;
    step();
    exc_req = 1'b0;
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL midexc_busy got=%b exp=1", busy); end
    reset = 1'b1;
    step();
    checks++; if (pc_out !== 32'h0) begin fails++; $display("FAIL midexc_pc got=%h exp=%h", pc_out, 32'h0); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL midexc_busy_clr got=%b exp=0", busy); end
    checks++; if (epc_out !== 32'h0) begin fails++; $display("FAIL midexc_epc got=%h exp=%h", epc_out, 32'h0); end
    checks++; if (sel_err !== 1'b0) begin fails++; $display("FAIL midexc_sel_err got=%b exp=0", sel_err); end
    reset = 1'b0;
    step();
    checks++; if (pc_out !== 32'h0) begin fails++; $display("FAIL post_reset_pc got=%h exp=%h", pc_out, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_uncond_write();
    test_cond_write();
    test_exception();
    test_exc_code3();
    test_sel_err();
    test_align();
    test_reset_mid_exception();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
